// File: rtl/gate_arb.sv
// Round-robin arbiter sharing one combinational two-input gate among N_REQ
// requesters: grant, drive the gate from registers, settle, and return the result.
module gate_arb #(
  parameter  int N_REQ = 4,
  parameter  int W     = 1,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       gate_a,
  output logic [W-1:0]       gate_b,
  input  logic [W-1:0]       gate_y,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_y,
  input  logic               rsp_ready
);
  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t                  state, state_nx;
  logic [IDW-1:0]          ptr, win, cand;
  logic [SW-1:0]           sum;
  logic                    found;
  logic [N_REQ-1:0][W-1:0] op_a, op_b;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*W +: W];
    assign op_b[i] = req_b[i*W +: W];
  end

  // First valid requester scanning upward from ptr, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      cand = sum[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = EVAL;
      EVAL:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gate drive is held through IDLE; ptr only moves once the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      gate_a    <= '0;
      gate_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gate_a <= op_a[win];
          gate_b <= op_b[win];
          rsp_id <= win;
        end
        EVAL: begin
          rsp_y     <= gate_y;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= (rsp_id == IDW'(N_REQ-1)) ? '0 : rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
